// File: rtl/cp_inserter_if.sv
// AXI4-Stream sample link between OFDM pipeline stages: tdata/tvalid/tlast
// forward, tready backward. master drives data, slave drives tready.
// Ports: tdata[W], tvalid, tlast, tready.
interface cp_inserter_if #(
  parameter int W = 32
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/cp_inserter.sv
// Purpose: buffers one N-sample IFFT symbol, then emits its last CP samples followed by the whole symbol.
// Latency: first CP sample is valid 1 cycle after the final input handshake; CP+N beats back-to-back at tready=1.
// Backpressure: output held stable while m tready=0; s tready=0 for the whole emission (no overlap).
//
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   s_axis_data        slave stream from the IFFT (tdata/tvalid/tlast/tready)
//   m_axis_data        master stream toward the DAC path
//   frame_err          one-cycle pulse when tlast disagrees with the N-sample length
//   symbol_count       completed output symbols, wraps at 16 bits
module cp_inserter #(
  parameter int N  = 16,
  parameter int CP = 8,
  parameter int W  = 32
) (
  input  logic          aclk,
  input  logic          aresetn,
  cp_inserter_if.slave  s_axis_data,
  cp_inserter_if.master m_axis_data,
  output logic          frame_err,
  output logic [15:0]   symbol_count
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] CP_START = IW'(N - CP);
  localparam logic [IW-1:0] ZERO_IDX = '0;

  typedef enum logic [1:0] {
    COLLECT,
    EMIT_CP,
    EMIT_BODY
  } state_t;

  state_t         state;
  logic [W-1:0]   sym_buf [N];
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  rd_idx;
  logic [IW-1:0]  rd_next;
  logic           s_rdy_q;
  logic           m_vld_q;
  logic           m_last_q;
  logic [W-1:0]   m_dat_q;
  logic           s_hs;
  logic           m_hs;
  logic           wr_last;
  logic           rd_last;
  logic [W-1:0]   cp_first_dat;

  assign s_axis_data.tready = s_rdy_q;
  assign m_axis_data.tvalid = m_vld_q;
  assign m_axis_data.tlast  = m_last_q;
  assign m_axis_data.tdata  = m_dat_q;

  assign s_hs    = s_axis_data.tvalid & s_rdy_q;
  assign m_hs    = m_vld_q & m_axis_data.tready;
  assign wr_last = (wr_idx == LAST_IDX);
  assign rd_last = (rd_idx == LAST_IDX);
  assign rd_next = rd_idx + IW'(1);

  // The first CP sample is loaded on the same edge that writes the final
  // input sample. With CP=1 that sample is the one being written, so it is
  // forwarded straight from the input instead of read from the buffer.
  assign cp_first_dat = (CP_START == LAST_IDX) ? s_axis_data.tdata : sym_buf[CP_START];

  // Symbol storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge aclk) begin
    if (s_hs) begin
      sym_buf[wr_idx] <= s_axis_data.tdata;
    end
  end

  // Control FSM. State names describe what the output register currently
  // holds: each output handshake loads the next sample, so the stream stays
  // gapless while tready is high and frozen while it is low.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= COLLECT;
      wr_idx       <= '0;
      rd_idx       <= '0;
      s_rdy_q      <= 1'b0;
      m_vld_q      <= 1'b0;
      m_last_q     <= 1'b0;
      m_dat_q      <= '0;
      frame_err    <= 1'b0;
      symbol_count <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        COLLECT: begin
          s_rdy_q <= 1'b1;
          if (s_hs) begin
            if (wr_last) begin
              // Length wins: a full symbol is emitted even without tlast.
              wr_idx    <= '0;
              rd_idx    <= CP_START;
              state     <= EMIT_CP;
              s_rdy_q   <= 1'b0;
              m_vld_q   <= 1'b1;
              m_last_q  <= 1'b0;
              m_dat_q   <= cp_first_dat;
              frame_err <= ~s_axis_data.tlast;
            end else if (s_axis_data.tlast) begin
              // Short frame: drop it and start over.
              wr_idx    <= '0;
              frame_err <= 1'b1;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end

        EMIT_CP: begin
          if (m_hs) begin
            if (rd_last) begin
              state   <= EMIT_BODY;
              rd_idx  <= ZERO_IDX;
              m_dat_q <= sym_buf[ZERO_IDX];
            end else begin
              rd_idx  <= rd_next;
              m_dat_q <= sym_buf[rd_next];
            end
          end
        end

        EMIT_BODY: begin
          if (m_hs) begin
            if (rd_last) begin
              state        <= COLLECT;
              rd_idx       <= '0;
              m_vld_q      <= 1'b0;
              m_last_q     <= 1'b0;
              s_rdy_q      <= 1'b1;
              symbol_count <= symbol_count + 16'd1;
            end else begin
              rd_idx   <= rd_next;
              m_dat_q  <= sym_buf[rd_next];
              m_last_q <= (rd_next == LAST_IDX);
            end
          end
        end

        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: doc/cp_inserter.md
Name: cp_inserter

Overview:
- Transmit-side consumer of the IFFT output AXI4-Stream in the 16-QAM OFDM chain (N=16, 32-bit samples, CP=8).
- Buffers one time-domain OFDM symbol of N samples.
- Emits the symbol prefixed by its last CP samples as an AXI4-Stream master: CP+N samples per symbol, toward the DAC/serializer path.

Parameters:
- N, 16, samples per OFDM symbol (IFFT length), >=2.
- CP, 8, cyclic-prefix length in samples, 1..N.
- W, 32, sample width; [31:16] real, [15:0] imaginary, two's complement.

Ports:
- aclk  in  1  system clock (100 MHz).
- aresetn  in  1  reset: asynchronous assert, active-low.
- s_axis_data_tdata  in  W  IFFT output sample.
- s_axis_data_tvalid  in  1  input sample valid.
- s_axis_data_tlast  in  1  last sample of the IFFT frame.
- s_axis_data_tready  out  1  block can accept a sample.
- m_axis_data_tdata  out  W  output sample (CP or body).
- m_axis_data_tvalid  out  1  output valid.
- m_axis_data_tlast  out  1  last sample of the CP+N symbol.
- m_axis_data_tready  in  1  downstream accepts the sample.
- frame_err  out  1  one-cycle pulse on a tlast/length mismatch.
- symbol_count  out  16  count of completed output symbols; wraps at 65535 -> 0.

Behaviour:
- Storage: N x W buffer, written at index wr_idx (0..N-1) on each input handshake (tvalid & tready).
- States: COLLECT, EMIT_CP, EMIT_BODY.
- COLLECT:
  - tready=1, m_tvalid=0.
  - On a handshake at wr_idx=N-1 -> EMIT_CP, rd_idx=N-CP, wr_idx=0.
  - On a handshake with tlast=1 at wr_idx<N-1: frame_err pulse, frame discarded, wr_idx=0, remain in COLLECT.
  - On a handshake at wr_idx=N-1 with tlast=0: frame_err pulse, frame still used (length is authoritative).
- EMIT_CP:
  - tready=0. Output buf[rd_idx].
  - On each output handshake, rd_idx+1.
  - After the handshake at rd_idx=N-1 -> EMIT_BODY, rd_idx=0.
- EMIT_BODY:
  - Output buf[rd_idx], rd_idx 0..N-1.
  - m_tlast=1 only while rd_idx=N-1.
  - On that handshake -> COLLECT, symbol_count+1.
- Output registers:
  - m_tdata, m_tvalid and m_tlast are registered.
  - m_tvalid rises the cycle after the final input handshake.
  - Latency is 1 cycle from the last input to the first CP sample.
  - With m_tready held at 1, the CP+N samples are emitted on consecutive cycles.
- AXI rules:
  - While m_tvalid=1 and m_tready=0, m_tdata and m_tlast are held stable and m_tvalid stays 1.
  - s_axis_data_tready does not depend combinationally on s_axis_data_tvalid.
  - m_axis_data_tvalid does not depend combinationally on m_axis_data_tready.
- No overlap: the next symbol is not accepted until the last body sample handshakes. Throughput is N input cycles plus CP+N output cycles per symbol.
- CP=N edge case: EMIT_CP starts at rd_idx=0; the output is the symbol twice.
- Input samples are passed bit-exact: no scaling or arithmetic.
- Reset (asynchronous, mid-operation included):
  - State=COLLECT, wr_idx=0, rd_idx=0, symbol_count=0.
  - m_tvalid=0, m_tlast=0, m_tdata=0, frame_err=0.
  - s_tready=1 from the first clock edge after aresetn deasserts.
  - Buffer contents are don't-care.

Test Plan:
- Nominal symbol: input tdata = {16'(i), 16'(-i)} for i=0..15, tlast at i=15, m_tready=1. Expected:
  - Output order i=8..15, then 0..15 (24 beats on consecutive cycles).
  - m_tlast only on beat 24 (i=15).
  - First m_tvalid 1 cycle after the input i=15 handshake.
  - symbol_count=1.
- Backpressure: same stimulus, m_tready toggled 1,0,0,1 repeating. Expected:
  - The identical 24-sample sequence.
  - tdata stable across stall cycles.
  - s_tready=0 throughout emission.
- Early tlast: tlast asserted at input i=9. Expected:
  - frame_err pulses once.
  - No output beats.
  - The next full 16-sample frame (tdata=0x100+i) produces 0x108..0x10F, 0x100..0x10F.
- Missing tlast: 16 samples with tlast=0. Expected: frame_err pulse on beat 16, and the symbol is still emitted as 24 beats.
- Reset mid-EMIT_BODY: aresetn dropped at output beat 12. Expected:
  - m_tvalid=0 immediately.
  - symbol_count=0.
  - s_tready=1 after release.
  - A fresh frame emits correctly.
- Back-to-back: 3 frames with input tvalid held at 1. Expected:
  - 72 output beats, 3 tlast pulses.
  - symbol_count=3.
  - No input accepted during any emission.
